// File: rtl/sobel_stream_ctrl.sv
// Frame sequencer for the Sobel row-buffer/convolution datapath: flow control, end-of-frame flush,
// datapath resync and SOF/EOL realignment. Define SOBEL_CTRL_PERF_EN to build the stall_cycles counter.
module sobel_stream_ctrl #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
  parameter int OUT_DELAY       = 36
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tuser,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tuser,
  output logic                  m_tlast,
  output logic [DATA_WIDTH-1:0] dp_inp_frame,
  input  logic [DATA_WIDTH-1:0] dp_out_frame,
  output logic                  dp_stall,
  output logic                  dp_aresetn,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output logic                  err_eol,
  output logic                  err_sof,
  output logic [31:0]           stall_cycles
);

  localparam int BPR     = IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int BPF     = BPR * IMAGE_DIM;
  localparam int CNT_MAX = (BPF > OUT_DELAY) ? BPF : OUT_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int COL_W   = $clog2(BPR + 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, RESYNC} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     beat_cnt, beat_cnt_nxt;
  logic [COL_W-1:0]     col, col_nxt;
  logic [OUT_DELAY-1:0] vpipe, upipe, lpipe;
  logic                 taken;
  logic                 out_ok, src_ok, adv, in_valid, in_sof, in_eol, accept_beat;

  // The datapath has no flow control, so one advance moves the whole pipe, sideband included.
  always_comb begin
    out_ok = ~m_tvalid | m_tready;
    src_ok = 1'b0;
    unique case (state)
      IDLE:    src_ok = s_tvalid & s_tuser;
      STREAM:  src_ok = s_tvalid;
      FLUSH:   src_ok = 1'b1;
      default: src_ok = 1'b0;
    endcase
    adv         = aresetn & src_ok & out_ok;
    in_valid    = (state == IDLE) || (state == STREAM);
    in_sof      = in_valid && (beat_cnt == '0);
    in_eol      = in_valid && (col == COL_W'(BPR - 1));
    accept_beat = adv & in_valid;
  end

  assign s_tready     = aresetn & (((state == IDLE) & ~s_tuser) | (in_valid & out_ok));
  assign dp_stall     = aresetn & ~adv;
  assign dp_inp_frame = accept_beat ? s_tdata : '0;
  assign dp_aresetn   = aresetn & (state != RESYNC);
  assign busy         = (state != IDLE);

  // A beat handed downstream while the source starves cannot leave the pipe yet; taken masks it until the next advance.
  assign m_tvalid = vpipe[OUT_DELAY-1] & ~taken;
  assign m_tuser  = upipe[OUT_DELAY-1] & ~taken;
  assign m_tlast  = lpipe[OUT_DELAY-1] & ~taken;
  assign m_tdata  = dp_out_frame;

  // beat_cnt counts frame beats while streaming and is reused as the flush beat counter.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    col_nxt      = col;
    unique case (state)
      IDLE, STREAM: begin
        if (adv) begin
          if (beat_cnt == CNT_W'(BPF - 1)) begin
            state_nxt    = FLUSH;
            beat_cnt_nxt = '0;
            col_nxt      = '0;
          end else begin
            state_nxt    = STREAM;
            beat_cnt_nxt = beat_cnt + 1'b1;
            col_nxt      = in_eol ? '0 : col + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (adv) begin
          if (beat_cnt == CNT_W'(OUT_DELAY - 1)) begin
            state_nxt    = RESYNC;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      RESYNC:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      col         <= '0;
      vpipe       <= '0;
      upipe       <= '0;
      lpipe       <= '0;
      taken       <= 1'b0;
      frame_count <= '0;
      err_eol     <= 1'b0;
      err_sof     <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      col      <= col_nxt;
      if (adv) begin
        vpipe <= {vpipe[OUT_DELAY-2:0], in_valid};
        upipe <= {upipe[OUT_DELAY-2:0], in_sof};
        lpipe <= {lpipe[OUT_DELAY-2:0], in_eol};
        taken <= 1'b0;
      end else if (m_tvalid && m_tready) begin
        taken <= 1'b1;
      end
      if (state == RESYNC) frame_count <= frame_count + 1'b1;
      // Sideband on the wire is only checked; the frame always follows the internal counters.
      err_eol <= accept_beat && (state == STREAM) && (s_tlast != in_eol);
      err_sof <= accept_beat && (state == STREAM) && s_tuser;
    end
  end

`ifdef SOBEL_CTRL_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      stall_cnt <= '0;
    end else if ((state == STREAM) && !adv && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Self-checking bench for sobel_stream_ctrl: a delay-line datapath stand-in, a frame-level
// scoreboard checked every cycle, and directed frames with hand-computed timing expectations.
`timescale 1ns/1ps
module tb_sobel_stream_ctrl;

  localparam int PPB = 16;
  localparam int DIM = 64;
  localparam int OD  = 8;
  localparam int DW  = 8 * PPB;
  localparam int BPR = 4;
  localparam int BPF = 256;
  localparam logic [DW-1:0] XMASK = {8{16'h5A3C}};

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tuser = 1'b0;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tuser;
  logic          m_tlast;
  logic [DW-1:0] dp_inp_frame;
  logic [DW-1:0] dp_out_frame;
  logic          dp_stall;
  logic          dp_aresetn;
  logic          busy;
  logic [15:0]   frame_count;
  logic          err_eol;
  logic          err_sof;
  logic [31:0]   stall_cycles;

  always #5 clk = ~clk;

  sobel_stream_ctrl #(
    .PIXELS_PER_BEAT(PPB),
    .IMAGE_DIM      (DIM),
    .DATA_WIDTH     (DW),
    .OUT_DELAY      (OD)
  ) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tuser     (s_tuser),
    .s_tlast     (s_tlast),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tuser     (m_tuser),
    .m_tlast     (m_tlast),
    .dp_inp_frame(dp_inp_frame),
    .dp_out_frame(dp_out_frame),
    .dp_stall    (dp_stall),
    .dp_aresetn  (dp_aresetn),
    .busy        (busy),
    .frame_count (frame_count),
    .err_eol     (err_eol),
    .err_sof     (err_sof),
    .stall_cycles(stall_cycles)
  );

  // Datapath stand-in: an OD-deep delay line that scrambles data so m_tdata provably comes from it.
  logic [DW-1:0] dp_line [OD];
  always @(posedge clk or negedge dp_aresetn) begin
    if (!dp_aresetn) begin
      for (int i = 0; i < OD; i++) dp_line[i] <= '0;
    end else if (!dp_stall) begin
      dp_line[0] <= dp_inp_frame ^ XMASK;
      for (int i = 1; i < OD; i++) dp_line[i] <= dp_line[i-1];
    end
  end
  assign dp_out_frame = dp_line[OD-1];

  typedef struct {
    logic [DW-1:0] data;
    logic          sof;
    logic          eol;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    model_cnt = 0;
  bit    draining = 0;
  bit    exp_eol = 0;
  bit    exp_sof = 0;
  bit    prev_hold = 0;
  beat_t held;
  logic [15:0] last_fc = '0;
  int    out_cnt, user_cnt, last_cnt, eol_pulses, sof_pulses, dp_low_cnt;
  int    first_mv_cyc, sof_cyc, last_acc_cyc, dp_rst_cyc;
  int    rdy_mode = 0;
  int    rdy_cnt = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Every cycle: sideband pulses, stall hold, drain quiet period and in-order output beats.
  always @(negedge clk) begin
    cyc++;
    if (!aresetn) begin
      exp_q.delete();
      model_cnt = 0;
      draining  = 0;
      exp_eol   = 0;
      exp_sof   = 0;
      prev_hold = 0;
      last_fc   = '0;
    end else begin
      checkOutput("err_eol", err_eol, exp_eol);
      checkOutput("err_sof", err_sof, exp_sof);
      exp_eol = 0;
      exp_sof = 0;
      eol_pulses += int'(err_eol);
      sof_pulses += int'(err_sof);
      if (frame_count != last_fc) begin
        draining = 0;
        last_fc  = frame_count;
      end
      if (!dp_aresetn) begin
        dp_low_cnt++;
        dp_rst_cyc = cyc;
      end
      if (draining) checkOutput("s_tready_drain", s_tready, 1'b0);
      if (prev_hold) begin
        checkOutput("hold_valid", m_tvalid, 1'b1);
        checkOutput("hold_data", m_tdata, held.data);
        checkOutput("hold_user", m_tuser, held.sof);
        checkOutput("hold_last", m_tlast, held.eol);
      end
      prev_hold = m_tvalid && !m_tready;
      if (prev_hold) begin
        checkOutput("dp_stall_hold", dp_stall, 1'b1);
        held.data = m_tdata;
        held.sof  = m_tuser;
        held.eol  = m_tlast;
      end
      if (m_tvalid && m_tready) begin
        if (first_mv_cyc < 0) first_mv_cyc = cyc;
        if (exp_q.size() == 0) begin
          checkOutput("spurious_beat", 1'b1, 1'b0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          checkOutput("m_tdata", m_tdata, e.data);
          checkOutput("m_tuser", m_tuser, e.sof);
          checkOutput("m_tlast", m_tlast, e.eol);
        end
        out_cnt++;
        user_cnt += int'(m_tuser);
        last_cnt += int'(m_tlast);
      end
      if (s_tvalid && s_tready && !(model_cnt == 0 && !s_tuser)) begin
        beat_t b;
        if (model_cnt == 0) begin
          sof_cyc = cyc;
        end else begin
          exp_eol = (s_tlast != ((model_cnt % BPR) == BPR - 1));
          exp_sof = s_tuser;
        end
        b.data = s_tdata ^ XMASK;
        b.sof  = (model_cnt == 0);
        b.eol  = ((model_cnt % BPR) == BPR - 1);
        exp_q.push_back(b);
        model_cnt++;
        if (model_cnt == BPF) begin
          model_cnt    = 0;
          draining     = 1;
          last_acc_cyc = cyc;
        end
      end
    end
  end

  // Downstream ready: always ready, or ready one cycle in three.
  always @(posedge clk) begin
    #1;
    rdy_cnt++;
    m_tready = (rdy_mode == 0) ? 1'b1 : ((rdy_cnt % 3) == 0);
  end

  function automatic logic [DW-1:0] pixels(input int tag, input int k);
    logic [15:0] w;
    w = {tag[7:0], k[7:0]};
    return {8{w}};
  endfunction

  task automatic sendBeat(input logic [DW-1:0] d, input logic u, input logic l, output bit ok);
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (s_tready) ok = 1;
      @(posedge clk);
      #1;
    end
    if (!ok) checkOutput("s_tready_timeout", 1'b0, 1'b1);
  endtask

  task automatic applyStimulus(input int tag, input int junk, input int bad_eol, input int bad_sof,
                               input int gap_at, input int gap_len, input int reset_at);
    bit ok;
    for (int j = 0; j < junk; j++) sendBeat({16{8'hA5}}, 1'b0, 1'b0, ok);
    for (int k = 0; k < BPF; k++) begin
      if (k == reset_at) begin
        aresetn = 1'b0;
        return;
      end
      sendBeat(pixels(tag, k), (k == 0) || (k == bad_sof), ((k % BPR) == BPR - 1) || (k == bad_eol), ok);
      if (!ok) return;
      if (k == gap_at) begin
        s_tvalid = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic waitDrain(input int fc);
    bit done;
    done = 0;
    s_tvalid = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      if (!busy && frame_count == 16'(fc)) done = 1;
    end
    checkOutput("drain_done", done, 1'b1);
    checkOutput("frame_count", frame_count, fc);
    checkOutput("queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clearStats();
    out_cnt = 0; user_cnt = 0; last_cnt = 0; eol_pulses = 0; sof_pulses = 0;
    dp_low_cnt = 0; first_mv_cyc = -1; sof_cyc = 0; last_acc_cyc = 0; dp_rst_cyc = 0;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_m_tvalid", m_tvalid, 1'b0);
    checkOutput("rst_m_tuser", m_tuser, 1'b0);
    checkOutput("rst_m_tlast", m_tlast, 1'b0);
    checkOutput("rst_m_tdata", m_tdata, '0);
    checkOutput("rst_s_tready", s_tready, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_frame_count", frame_count, 0);
    checkOutput("rst_err_eol", err_eol, 1'b0);
    checkOutput("rst_err_sof", err_sof, 1'b0);
    checkOutput("rst_dp_aresetn", dp_aresetn, 1'b0);
    checkOutput("rst_dp_inp_frame", dp_inp_frame, '0);
    checkOutput("rst_stall_cycles", stall_cycles, 0);
  endtask

  int lacc;
  logic [31:0] stall0;

  initial begin
    clearStats();
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs();
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_dp_aresetn", dp_aresetn, 1'b1);
    checkOutput("idle_busy", busy, 1'b0);

    $display("[TB] full frame at full throughput");
    clearStats();
    applyStimulus(1, 0, -1, -1, -1, 0, -1);
    waitDrain(1);
    checkOutput("t1_out_beats", out_cnt, 256);
    checkOutput("t1_sof_beats", user_cnt, 1);
    checkOutput("t1_eol_beats", last_cnt, 64);
    checkOutput("t1_first_latency", first_mv_cyc - sof_cyc, 8);
    checkOutput("t1_resync_at", dp_rst_cyc - sof_cyc, 264);
    checkOutput("t1_dp_rst_cycles", dp_low_cnt, 1);

    $display("[TB] back-to-back frames");
    clearStats();
    applyStimulus(2, 0, -1, -1, -1, 0, -1);
    lacc = last_acc_cyc;
    applyStimulus(3, 0, -1, -1, -1, 0, -1);
    checkOutput("b2b_sof_gap", sof_cyc - lacc, 10);
    waitDrain(3);
    checkOutput("b2b_out_beats", out_cnt, 512);

    $display("[TB] non-SOF beats in IDLE");
    clearStats();
    applyStimulus(4, 3, -1, -1, -1, 0, -1);
    waitDrain(4);
    checkOutput("t2_out_beats", out_cnt, 256);
    checkOutput("t2_sof_beats", user_cnt, 1);

    $display("[TB] downstream ready one cycle in three");
    clearStats();
    rdy_mode = 1;
    applyStimulus(5, 0, -1, -1, -1, 0, -1);
    waitDrain(5);
    rdy_mode = 0;
    checkOutput("t3_out_beats", out_cnt, 256);
    checkOutput("t3_eol_beats", last_cnt, 64);

    $display("[TB] wrong EOL and SOF sideband");
    clearStats();
    applyStimulus(6, 0, 5, 10, -1, 0, -1);
    waitDrain(6);
    checkOutput("t4_eol_pulses", eol_pulses, 1);
    checkOutput("t4_sof_pulses", sof_pulses, 1);
    checkOutput("t4_eol_beats", last_cnt, 64);
    checkOutput("t4_out_beats", out_cnt, 256);

    $display("[TB] reset mid-frame");
    applyStimulus(7, 0, -1, -1, -1, 0, 100);
    #2;
    checkResetOutputs();
    repeat (3) @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    aresetn  = 1'b1;
    @(posedge clk);
    #1;
    clearStats();
    applyStimulus(8, 0, -1, -1, -1, 0, -1);
    waitDrain(1);
    checkOutput("t5_out_beats", out_cnt, 256);
    checkOutput("t5_sof_beats", user_cnt, 1);

    $display("[TB] source gap of 10 cycles mid-frame");
    clearStats();
    stall0 = stall_cycles;
    applyStimulus(9, 0, -1, -1, 100, 10, -1);
    waitDrain(2);
    checkOutput("t6_out_beats", out_cnt, 256);
`ifdef SOBEL_CTRL_PERF_EN
    checkOutput("t6_stall_cycles", stall_cycles - stall0, 10);
`else
    checkOutput("t6_stall_cycles", stall_cycles, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
